icache_direct: RTL and testbench

- Direct-mapped instruction cache between the fetch unit (upstream) and the memory controller (downstream).
- Serves fetch hits combinationally in the same cycle.
- On a miss, issues a 32-bit word request on the controller's instruction port and holds it until the one-cycle completion pulse.
- Fills the line, then lets the fetch retry, which then hits.

---
 rtl/icache_direct_pkg.sv | 13 +
 rtl/icache_line_array.sv | 48 ++++
 rtl/icache_direct.sv | 146 ++++++++++++++
 tb/tb_icache_direct.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry
// and FSM state encodings.
package icache_direct_pkg;

    localparam int ICACHE_INDEX_BITS = 6;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_MISS = 2'd1,
        IC_COOL = 2'd2
    } ic_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache: combinational
// read by index, synchronous single write port; reset clears only the valid bits.
module icache_line_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rindex,
    output logic                  rvalid,
    output logic [TAG_BITS-1:0]   rtag,
    output logic [31:0]           rdata,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] windex,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [31:0]           wdata
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_r  [LINES];
    logic [31:0]         data_r [LINES];

    assign rvalid = valid_r[rindex];
    assign rtag   = tag_r[rindex];
    assign rdata  = data_r[rindex];

    // Valid bits: cleared by reset, set by a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (we) begin
            valid_r[windex] <= 1'b1;
        end
    end

    // Tag and data payload; never reset, qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_r[windex]  <= wtag;
            data_r[windex] <= wdata;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: same-cycle hits, single-word miss fill from
// the memory controller. Optional hit/miss counters under ICACHE_PERF_COUNTER_EN.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic [31:0] mc_data,
    input  logic        mc_done
`ifdef ICACHE_PERF_COUNTER_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    ic_state_t           state_r;
    logic [29:0]         miss_word_r;
    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0] tag_s;
    logic                line_valid_s;
    logic [TAG_BITS-1:0] line_tag_s;
    logic [31:0]         line_data_s;
    logic                hit_s;
    logic                inst_valid_s;
    logic                miss_s;
    logic                fill_we_s;
    logic                mc_req_s;
    logic                unused_ok_s;

    assign index_s     = fetch_pc[INDEX_BITS+1:2];
    assign tag_s       = fetch_pc[31:INDEX_BITS+2];
    assign unused_ok_s = ^fetch_pc[1:0];

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk    (clk),
        .rst    (rst),
        .rindex (index_s),
        .rvalid (line_valid_s),
        .rtag   (line_tag_s),
        .rdata  (line_data_s),
        .we     (fill_we_s),
        .windex (miss_word_r[INDEX_BITS-1:0]),
        .wtag   (miss_word_r[29:INDEX_BITS]),
        .wdata  (mc_data)
    );

    // Hit/miss decode and controller handshake; everything is gated by rdy.
    always_comb begin
        hit_s        = line_valid_s && (line_tag_s == tag_s);
        inst_valid_s = 1'b0;
        miss_s       = 1'b0;
        if (rdy && (state_r == IC_IDLE) && fetch_req && !flush) begin
            inst_valid_s = hit_s;
            miss_s       = !hit_s;
        end else begin
            inst_valid_s = 1'b0;
            miss_s       = 1'b0;
        end
        mc_req_s  = rdy && (state_r == IC_MISS);
        fill_we_s = mc_req_s && mc_done;
    end

    // Output drive; data and address are forced to zero when not qualified.
    always_comb begin
        inst_valid = inst_valid_s;
        mc_req     = mc_req_s;
        if (inst_valid_s) begin
            inst_data = line_data_s;
        end else begin
            inst_data = 32'd0;
        end
        if (mc_req_s) begin
            mc_addr = {miss_word_r, 2'b00};
        end else begin
            mc_addr = 32'd0;
        end
    end

    // Miss FSM; a flush in MISS does not cancel the in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IC_IDLE;
            miss_word_r <= 30'd0;
        end else if (rdy) begin
            case (state_r)
                IC_IDLE: begin
                    if (miss_s) begin
                        miss_word_r <= fetch_pc[31:2];
                        state_r     <= IC_MISS;
                    end
                end
                IC_MISS: begin
                    if (mc_done) begin
                        state_r <= IC_COOL;
                    end
                end
                IC_COOL: begin
                    state_r <= IC_IDLE;
                end
                default: begin
                    state_r <= IC_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Free-running wrap-around counters, frozen with rdy via the gated strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (inst_valid_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic [31:0] mc_data;
    logic        mc_done;
`ifdef ICACHE_PERF_COUNTER_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icache_direct dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetch_req  (fetch_req),
        .fetch_pc   (fetch_pc),
        .flush      (flush),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .mc_req     (mc_req),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .mc_done    (mc_done)
`ifdef ICACHE_PERF_COUNTER_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a 64-entry map of word address -> instruction, plus
    // "waiting for a word" and "one quiet cycle after a fill" flags.
    bit          m_live = 1'b0;
    bit          m_has  [64];
    logic [31:0] m_word [64];
    logic [31:0] m_data [64];
    bit          m_waiting;
    bit          m_quiet;
    logic [31:0] m_addr;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic bit model_hit();
        int s;
        s = slot_of(fetch_pc);
        return m_has[s] && (m_word[s] == (fetch_pc / 4));
    endfunction

    function automatic bit model_serving();
        return rdy && !m_waiting && !m_quiet && fetch_req && !flush;
    endfunction

    // Model update on each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_live    <= 1'b1;
            m_waiting <= 1'b0;
            m_quiet   <= 1'b0;
            m_hits    <= 32'd0;
            m_misses  <= 32'd0;
            for (int i = 0; i < 64; i++) m_has[i] <= 1'b0;
        end else if (rdy && m_live) begin
            if (m_quiet) begin
                m_quiet <= 1'b0;
            end else if (m_waiting) begin
                if (mc_done) begin
                    m_has[slot_of(m_addr)]  <= 1'b1;
                    m_word[slot_of(m_addr)] <= m_addr / 4;
                    m_data[slot_of(m_addr)] <= mc_data;
                    m_waiting <= 1'b0;
                    m_quiet   <= 1'b1;
                end
            end else if (model_serving()) begin
                if (model_hit()) begin
                    m_hits <= m_hits + 32'd1;
                end else begin
                    m_waiting <= 1'b1;
                    m_addr    <= fetch_pc & 32'hFFFF_FFFC;
                    m_misses  <= m_misses + 32'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            logic        ev;
            logic [31:0] ed;
            ev = model_serving() && model_hit();
            ed = ev ? m_data[slot_of(fetch_pc)] : 32'd0;
            check("model_inst_valid", {31'd0, inst_valid}, {31'd0, ev});
            check("model_inst_data", inst_data, ed);
            check("model_mc_req", {31'd0, mc_req}, {31'd0, rdy && m_waiting});
            check("model_mc_addr", mc_addr, (rdy && m_waiting) ? m_addr : 32'd0);
`ifdef ICACHE_PERF_COUNTER_EN
            check("model_hit_cnt", hit_cnt, m_hits);
            check("model_miss_cnt", miss_cnt, m_misses);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, pin its address, then deliver a word.
    task automatic serve(input string name, input logic [31:0] exp_addr,
                         input logic [31:0] data, input int lat);
        int n;
        n = 0;
        while (!mc_req && n < 20) begin
            step();
            n++;
        end
        check({name, "_req_seen"}, {31'd0, mc_req}, 32'd1);
        check({name, "_addr"}, mc_addr, exp_addr);
        repeat (lat) step();
        check({name, "_addr_held"}, mc_addr, exp_addr);
        mc_done = 1'b1;
        mc_data = data;
        step();
        mc_done = 1'b0;
        mc_data = 32'd0;
        sample();
        check({name, "_cool_req"}, {31'd0, mc_req}, 32'd0);
        check({name, "_cool_valid"}, {31'd0, inst_valid}, 32'd0);
        step();
        sample();
        check({name, "_retry_valid"}, {31'd0, inst_valid}, 32'd1);
        check({name, "_retry_data"}, inst_data, data);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; fetch_pc = 32'd0;
        flush = 1'b0; mc_data = 32'd0; mc_done = 1'b0;
        step(); step();
        sample();
        check("reset_mc_req", {31'd0, mc_req}, 32'd0);
        check("reset_mc_addr", mc_addr, 32'd0);
        check("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_inst_data", inst_data, 32'd0);
        step();
        rst = 1'b0;

        // Cold miss on 0x0.
        fetch_req = 1'b1; fetch_pc = 32'h0000_0000;
        sample();
        check("cold_first_valid", {31'd0, inst_valid}, 32'd0);
        step();
        serve("cold", 32'h0000_0000, 32'h0000_0413, 5);

        // Hit with low address bits set; stray mc_done in IDLE is ignored.
        step();
        fetch_pc = 32'h0000_0002; mc_done = 1'b1; mc_data = 32'hDEAD_BEEF;
        sample();
        check("hit_valid", {31'd0, inst_valid}, 32'd1);
        check("hit_data", inst_data, 32'h0000_0413);
        check("hit_no_req", {31'd0, mc_req}, 32'd0);
        step();
        mc_done = 1'b0; mc_data = 32'd0;
        sample();
        check("stray_done_data", inst_data, 32'h0000_0413);

        // Conflict on index 0, then the original address misses again.
        fetch_pc = 32'h0000_0100;
        step();
        serve("conflict", 32'h0000_0100, 32'h00A0_0093, 3);
        step();
        fetch_pc = 32'h0000_0000;
        sample();
        check("evicted_valid", {31'd0, inst_valid}, 32'd0);
        step();
        serve("refill", 32'h0000_0000, 32'h0000_0413, 2);

        // Flush two cycles into a miss does not abort it.
        step();
        fetch_pc = 32'h0000_0040;
        step();
        step(); step();
        flush = 1'b1;
        sample();
        check("flush_req_held", {31'd0, mc_req}, 32'd1);
        check("flush_addr_held", mc_addr, 32'h0000_0040);
        step();
        flush = 1'b0;
        serve("flushfill", 32'h0000_0040, 32'h1234_5678, 1);
        step();
        flush = 1'b1;
        sample();
        check("flush_idle_valid", {31'd0, inst_valid}, 32'd0);
        step();
        flush = 1'b0;
        fetch_pc = 32'h0000_0044;
        flush = 1'b1;
        step();
        sample();
        check("flush_idle_no_miss", {31'd0, mc_req}, 32'd0);
        flush = 1'b0;

        // Reset in the middle of a miss clears everything.
        fetch_pc = 32'h0000_0080;
        step(); step();
        sample();
        check("pre_reset_req", {31'd0, mc_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fetch_req = 1'b0;
        sample();
        check("post_reset_req", {31'd0, mc_req}, 32'd0);
        fetch_req = 1'b1; fetch_pc = 32'h0000_0000;
        sample();
        check("post_reset_miss", {31'd0, inst_valid}, 32'd0);
        step();
        serve("postreset", 32'h0000_0000, 32'h0000_0413, 1);

        // rdy stall in MISS while mc_done pulses: no fill.
        step();
        fetch_pc = 32'h0000_00C0;
        step(); step();
        rdy = 1'b0; mc_done = 1'b1; mc_data = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("stall_req", {31'd0, mc_req}, 32'd0);
            check("stall_valid", {31'd0, inst_valid}, 32'd0);
            step();
        end
        rdy = 1'b1; mc_done = 1'b0; mc_data = 32'd0;
        sample();
        check("stall_resume_req", {31'd0, mc_req}, 32'd1);
        check("stall_resume_addr", mc_addr, 32'h0000_00C0);
        step();
        serve("stallfill", 32'h0000_00C0, 32'h0051_0113, 2);

        step();
        fetch_req = 1'b0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
